// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
//   Request/result bundle between the control unit and the multiply/divide
//   engine.
//   master : control side, drives start/op/a/b and observes the results.
//   slave  : engine side, consumes the request and drives hi/lo/busy/done/
//            div_by_zero.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output hi, lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Multi-cycle signed multiply / divide engine feeding the Hi/Lo registers.
//   One bit is processed per clock on operand magnitudes (shift-add multiply,
//   restoring divide); signs are applied in a final fix-up cycle.
//   Ports:
//     clk    : system clock, rising edge
//     reset  : synchronous, active-high; clears all state
//     bus    : slave side of muldiv_unit_if
//              start/op/a/b in; hi/lo/busy/done/div_by_zero out
//   Timing: request accepted at edge E0, result written at E(WIDTH+1),
//   done high for the single cycle after that edge.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_q;
  logic             op_q;
  logic             sign_a_q, sign_b_q;
  logic [WIDTH:0]   mag_a_q, mag_b_q;   // one spare bit so |most-negative| fits
  logic [WIDTH:0]   rem_q;              // mul: upper partial product; div: remainder
  logic [WIDTH-1:0] quo_q;              // mul: multiplier / lower product; div: dividend / quotient
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q, dbz_q;

  // Magnitudes of the incoming operands, sign-extended by one bit first.
  logic [WIDTH:0] a_ext, b_ext, mag_a_in, mag_b_in;
  assign a_ext    = {bus.a[WIDTH-1], bus.a};
  assign b_ext    = {bus.b[WIDTH-1], bus.b};
  assign mag_a_in = bus.a[WIDTH-1] ? (WIDTH+1)'(-a_ext) : a_ext;
  assign mag_b_in = bus.b[WIDTH-1] ? (WIDTH+1)'(-b_ext) : b_ext;

  // One iteration of the active algorithm.
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    mul_sum = quo_q[0] ? (rem_q + mag_a_q) : rem_q;
    shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    diff    = shifted - mag_b_q;
    if (!op_q) begin
      // Add-then-shift right; the low product bits enter quo_q from the top.
      rem_d = {1'b0, mul_sum[WIDTH:1]};
      quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
    end else if (shifted >= mag_b_q) begin
      rem_d = diff;
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shifted;
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix-up of the magnitude results.
  logic [2*WIDTH-1:0] prod_mag, prod_signed;
  logic [WIDTH-1:0]   quo_signed, rem_signed;
  assign prod_mag    = {rem_q[WIDTH-1:0], quo_q};
  assign prod_signed = (sign_a_q ^ sign_b_q) ? -prod_mag : prod_mag;
  assign quo_signed  = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
  assign rem_signed  = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q     <= bus.op;
            sign_a_q <= bus.a[WIDTH-1];
            sign_b_q <= bus.b[WIDTH-1];
            mag_a_q  <= mag_a_in;
            mag_b_q  <= mag_b_in;
            rem_q    <= '0;
            // Multiply walks the multiplier bits; divide shifts the dividend in.
            quo_q    <= bus.op ? mag_a_in[WIDTH-1:0] : mag_b_in[WIDTH-1:0];
            cnt_q    <= '0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= FIX;
        end
        FIX: begin
          if (!op_q) begin
            hi_q <= prod_signed[2*WIDTH-1:WIDTH];
            lo_q <= prod_signed[WIDTH-1:0];
          end else if (mag_b_q == '0) begin
            // Divide by zero: the remainder path already holds |a|, so the
            // signed remainder reproduces a.
            hi_q  <= rem_signed;
            lo_q  <= '1;
            dbz_q <= 1'b1;
          end else begin
            hi_q <= rem_signed;
            lo_q <= quo_signed;
          end
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  // Result of an operation from plain signed arithmetic: {dbz, hi, lo}.
  function automatic logic [2*W:0] model_result(input logic op,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb, q, r;
    longint p;
    sa = a;
    sb = b;
    if (!op) begin
      p = longint'(sa) * longint'(sb);
      return {1'b0, p[63:0]};
    end
    if (b == 0) return {1'b1, a, {W{1'b1}}};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r, q};
  endfunction

  logic         m_busy = 0, m_done = 0, m_dbz = 0;
  logic [W-1:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  logic         p_dbz = 0;
  int           m_cnt = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 0; m_done <= 0; m_dbz <= 0;
      m_hi <= 0; m_lo <= 0; m_cnt <= 0;
    end else begin
      m_done <= 0;
      if (!m_busy) begin
        if (bus.start) begin
          m_busy <= 1;
          m_cnt  <= 0;
          m_dbz  <= 0;
          {p_dbz, p_hi, p_lo} <= model_result(bus.op, bus.a, bus.b);
        end
      end else begin
        m_cnt <= m_cnt + 1;
        if (m_cnt + 1 == W + 1) begin
          m_hi <= p_hi; m_lo <= p_lo; m_dbz <= p_dbz; m_done <= 1;
        end
        if (m_cnt + 1 == W + 2) m_busy <= 0;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  logic chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo} !==
          {m_busy, m_done, m_dbz, m_hi, m_lo}) begin
        errors++;
        $display("FAIL cycle_model t=%0t: busy/done/dbz/hi/lo got %b/%b/%b/%h/%h want %b/%b/%b/%h/%h",
                 $time, bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo,
                 m_busy, m_done, m_dbz, m_hi, m_lo);
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Issue one request in the next cycle, wait for done and pin hand-computed results.
  task automatic run_op(input string name, input logic op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input logic exp_dbz, input bit inject);
    int n;
    @(negedge clk);
    bus.start = 1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 0;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (inject && n == 5) begin
        bus.start = 1; bus.op = ~op; bus.a = 32'h1234_5678; bus.b = 32'h0000_0003;
      end
      if (inject && n == 6) bus.start = 0;
    end
    check({name, "_latency"}, n, 33);
    check({name, "_hi"}, bus.hi, exp_hi);
    check({name, "_lo"}, bus.lo, exp_lo);
    check({name, "_dbz"}, {31'b0, bus.div_by_zero}, {31'b0, exp_dbz});
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d edges=%0d (%s)",
             op, a, b, bus.hi, bus.lo, bus.div_by_zero, n, name);
  endtask

  initial begin
    int seen;
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
    reset = 1;
    repeat (2) @(negedge clk);
    check("reset_hi", bus.hi, 0);
    check("reset_lo", bus.lo, 0);
    check("reset_flags", {29'b0, bus.busy, bus.done, bus.div_by_zero}, 0);
    reset = 0;
    chk_en = 1;

    run_op("mul_7_m3",    0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0);
    run_op("mul_min_min", 0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 0);
    run_op("mul_m1_m1",   0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0, 0);
    run_op("div_m7_2",    1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
    run_op("div_100_7",   1, 32'd100,        32'd7,         32'd2,         32'd14,        0, 0);
    run_op("div_m100_m7", 1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14,        0, 0);
    run_op("div_min_m1",  1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 0);
    run_op("div_5_0",     1, 32'd5,          32'd0,         32'd5,         32'hFFFF_FFFF, 1, 0);
    run_op("div_m9_0",    1, 32'hFFFF_FFF7,  32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF, 1, 0);
    // Start pulsed mid-run is ignored; the following call starts back-to-back.
    run_op("mul_inject",  0, 32'd1000,       32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_F830, 0, 1);
    run_op("div_b2b",     1, 32'd17,         32'hFFFF_FFFB, 32'd2,         32'hFFFF_FFFD, 0, 0);

    // Reset at E10 of a divide.
    @(negedge clk);
    bus.start = 1; bus.op = 1; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 0;
    repeat (9) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("midreset_busy", {31'b0, bus.busy}, 0);
    check("midreset_hi", bus.hi, 0);
    check("midreset_lo", bus.lo, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    check("midreset_no_done", seen, 0);
    $display("reset mid-divide: busy=%0d hi=%h lo=%h done_pulses=%0d", bus.busy, bus.hi, bus.lo, seen);
    run_op("mul_3_4",     0, 32'd3,          32'd4,         32'd0,         32'd12,        0, 0);

    // Reset and start in the same cycle: request dropped.
    @(negedge clk);
    reset = 1; bus.start = 1; bus.op = 0; bus.a = 32'd9; bus.b = 32'd9;
    @(negedge clk);
    reset = 0; bus.start = 0;
    @(negedge clk);
    check("reset_start_busy", {31'b0, bus.busy}, 0);
    $display("reset+start: busy=%0d", bus.busy);
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
